// File: rtl/mdu_scheduler.sv
// Shares one multiplier/divider pair between the alpha and beta issue pipelines:
// arbitrates, latches operands, pulses the unit, waits for done and commits HI/LO.
module mdu_scheduler #(
   parameter int ARB_MODE = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush_i,
   input  logic        a_req,
   input  logic [1:0]  a_kind,
   input  logic [31:0] a_src_a,
   input  logic [31:0] a_src_b,
   input  logic        a_hilo_rd,
   input  logic        b_req,
   input  logic [1:0]  b_kind,
   input  logic [31:0] b_src_a,
   input  logic [31:0] b_src_b,
   input  logic        b_hilo_rd,
   output logic        a_grant,
   output logic        b_grant,
   output logic        a_stall,
   output logic        b_stall,
   output logic [1:0]  mult_op,
   output logic [1:0]  div_op,
   output logic [31:0] op_a,
   output logic [31:0] op_b,
   input  logic        mult_done,
   input  logic        div_done,
   input  logic [63:0] mult_res,
   input  logic [63:0] div_res,
   output logic        hilo_wen,
   output logic [63:0] hilo_result,
   output logic        busy
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LAUNCH = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_COMMIT = 2'd3;

   logic [1:0]  state;
   logic        sel_div, sel_signed, kill;
   logic        seen_low, wait_cnt;
   logic        rr_beta;
   logic        arb_ok, pick_b, win_a, win_b;
   logic [1:0]  win_kind;
   logic        unit_done;
   logic [63:0] unit_res;

   // rr_beta: beta has priority on the next tie (only consulted in round-robin mode)
   always_comb begin
      arb_ok = (state == S_IDLE) && !flush_i && !rst;
      pick_b = b_req;
      if (a_req && b_req)
         pick_b = (ARB_MODE != 0) && rr_beta;
      win_a    = arb_ok && a_req && !pick_b;
      win_b    = arb_ok && b_req && pick_b;
      win_kind = win_b ? b_kind : a_kind;
   end

   assign a_grant = win_a;
   assign b_grant = win_b;
   assign busy    = (state != S_IDLE);

   // HI/LO readers hold through COMMIT so they see the committed value next cycle
   assign a_stall = !rst && !flush_i && ((a_req && !win_a) || (a_hilo_rd && busy));
   assign b_stall = !rst && !flush_i && ((b_req && !win_b) || (b_hilo_rd && busy));

   assign mult_op = (state == S_LAUNCH && !sel_div) ? (sel_signed ? 2'b10 : 2'b01) : 2'b00;
   assign div_op  = (state == S_LAUNCH &&  sel_div) ? (sel_signed ? 2'b10 : 2'b01) : 2'b00;

   assign unit_done   = sel_div ? div_done : mult_done;
   assign unit_res    = sel_div ? div_res  : mult_res;
   assign hilo_wen    = (state == S_COMMIT) && !kill;
   assign hilo_result = hilo_wen ? unit_res : 64'd0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         op_a       <= 32'd0;
         op_b       <= 32'd0;
         sel_div    <= 1'b0;
         sel_signed <= 1'b0;
         kill       <= 1'b0;
         seen_low   <= 1'b0;
         wait_cnt   <= 1'b0;
         rr_beta    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (win_a || win_b) begin
                  op_a       <= win_b ? b_src_a : a_src_a;
                  op_b       <= win_b ? b_src_b : a_src_b;
                  sel_div    <= win_kind[1];
                  sel_signed <= !win_kind[0];
                  rr_beta    <= win_a;
                  state      <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               seen_low <= 1'b0;
               wait_cnt <= 1'b0;
               if (flush_i) kill <= 1'b1;
               state <= S_WAIT;
            end
            S_WAIT: begin
               // the unit cannot be aborted; a flush only drops the result
               if (flush_i) kill <= 1'b1;
               if (!unit_done)
                  seen_low <= 1'b1;
               else if (seen_low || wait_cnt)
                  state <= S_COMMIT;
               else
                  wait_cnt <= 1'b1;
            end
            S_COMMIT: begin
               kill  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/mdu_scheduler.md
Name: mdu_scheduler

Overview:
- Sequences the single shared multiply/divide unit pair (multiplier + divider) between the alpha and beta issue pipelines.
- Arbitrates MDU requests and latches operands. Issues one-cycle op pulses to the units and detects completion on the rising edge of their done signals.
- Commits the 64-bit result to HI/LO and stalls any requester that needs the unit or HI/LO while an operation is in flight.
- Sits between the issue stage and the multiplier/divider instances. It replaces per-pipeline MDU control.

Parameters:
ARB_MODE, 0, 0 = fixed priority (alpha wins), 1 = round-robin (last-granted loses a tie)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush_i  in  1  pipeline flush; cancels un-granted requests and discards the in-flight result
a_req  in  1  alpha MDU request valid
a_kind  in  2  alpha op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a_src_a  in  32  alpha operand A (dividend / multiplicand)
a_src_b  in  32  alpha operand B (divisor / multiplier)
a_hilo_rd  in  1  alpha instruction reads HI/LO (MFHI/MFLO)
b_req, b_kind, b_src_a, b_src_b, b_hilo_rd  in  1/2/32/32/1  beta equivalents
a_grant  out  1  one-cycle pulse: alpha request accepted
b_grant  out  1  one-cycle pulse: beta request accepted
a_stall  out  1  alpha must hold
b_stall  out  1  beta must hold
mult_op  out  2  to multiplier: 10 signed, 01 unsigned, 00 none
div_op  out  2  to divider: 10 signed, 01 unsigned, 00 none
op_a  out  32  latched operand A to units
op_b  out  32  latched operand B to units
mult_done  in  1  multiplier idle/done level
div_done  in  1  divider idle/done level
mult_res  in  64  multiplier {hi, lo}
div_res  in  64  divider {remainder, quotient}
hilo_wen  out  1  commit strobe
hilo_result  out  64  value to commit
busy  out  1  unit occupied (state != IDLE)

Behaviour:
- Reset (async): state IDLE.
  - All outputs 0: op pulses, grants, stalls, hilo_wen, hilo_result, op_a, op_b.
  - Round-robin pointer set to alpha.
  - kill flag cleared.
- States:
  - IDLE: arbitration runs each cycle when flush_i=0.
    - Winner: the only requester; if both request, alpha (ARB_MODE=0) or the one not granted last (ARB_MODE=1).
    - On a win: pulse that requester's grant. Register op_a/op_b from the winner's operands, latch kind into sel_div/sel_signed. Go to LAUNCH.
  - LAUNCH (exactly 1 cycle): drive mult_op or div_op per the latched kind. Go to WAIT.
  - WAIT: sample the selected unit's done each cycle.
    - First leave a "seen_low" phase: done must be observed 0 at least once.
    - Then a 0→1 transition means complete: go to COMMIT.
    - If done stays 1 for 2 cycles after LAUNCH (zero-latency unit), treat it as complete.
  - COMMIT (1 cycle): hilo_wen=1 and hilo_result = selected unit result, unless kill=1. Clear kill. Go to IDLE.
    - Arbitration is not performed in COMMIT. A new grant is earliest in the cycle after COMMIT, so HI/LO is written before any dependent op launches.
- Stalls (combinational):
  - x_stall=1 if x_req=1 and x is not granted this cycle.
  - x_stall=1 if x_hilo_rd=1 and state != IDLE. A read in the COMMIT cycle also stalls; it proceeds the next cycle with the bypass-free HI/LO.
  - flush_i=1 forces both stalls and both grants to 0.
- Flush:
  - In IDLE, flush_i=1: no grant.
  - In LAUNCH or WAIT: the unit cannot be aborted. Set kill, keep sequencing to COMMIT, suppress hilo_wen. busy stays 1 until back in IDLE.
  - In COMMIT: the commit proceeds. The instruction already retired past the flush point.
- Operands: op_a/op_b hold stable from LAUNCH through COMMIT. The upstream source may change after grant.
- No back-to-back overlap: at most one op in flight. Latency from grant to hilo_wen = unit latency + 2.
- Round-robin pointer updates only on a grant, not on flushed cycles.

Test Plan:
- Single alpha MULT, a=0xFFFF_FFFF, b=2 → a_grant pulse, mult_op=10 for 1 cycle, hilo_wen once with 0xFFFF_FFFF_FFFF_FFFE, busy falls the cycle after.
- Alpha DIVU and beta MULTU requested the same cycle, ARB_MODE=0 → alpha granted, beta stalled. After the alpha commit (7/2 → hilo 0x1_0000_0003), beta is granted and commits. Repeat with ARB_MODE=1 after a prior alpha grant → beta granted first.
- Beta MFLO (b_hilo_rd=1) issued during an alpha DIV of -7/2 → b_stall held through COMMIT. Released the next cycle, with HI/LO already written as {0xFFFF_FFFF, 0xFFFF_FFFD}.
- flush_i pulsed during WAIT of a DIV → no hilo_wen. busy stays until the unit's done rises. A request in the flush cycle is not granted.
- rst asserted mid-WAIT (asynchronously, between clock edges) → all outputs 0 immediately, state IDLE. A new MULT issued after reset completes correctly.
- Multiplier model with done never going low → completes via the 2-cycle rule, with exactly one hilo_wen.
